// File: rtl/data_mem_stage.sv
// Purpose : pipeline memory-access stage with a 256-byte big-endian data RAM (byte/word loads and stores).
// Latency : WAIT_STATES extra cycles per access; mem_done and load data in cycle WAIT_STATES after the request.
// Backpres: mem_stall holds the upstream pipeline while wait states are being counted; flush by dropping the request.
//
// Ports:
//   clk, R (async active-low reset)
//   MEM_Enable_signal / MEM_RW_enable (1=store) / MEM_Size_enable (1=word) / address / data_in : request from EX/MEM
//   data_out  : load data to MEM/WB (0 for stores and when idle)
//   mem_stall : hold PC..EX/MEM, bubble into MEM/WB
//   mem_done  : access completes at the coming edge
//   misalign  : misaligned word access flag
// Optional feature: define DATA_MEM_ALIGN_CHECK_EN to flag misaligned word accesses,
// suppress their stores and force their load data to 0. Without it, misalign is 0 and
// unaligned words simply wrap modulo 256.
module data_mem_stage #(
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        R,
    input  logic        MEM_Enable_signal,
    input  logic        MEM_RW_enable,
    input  logic        MEM_Size_enable,
    input  logic [7:0]  address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        mem_stall,
    output logic        mem_done,
    output logic        misalign
);

    localparam logic [3:0] WS    = 4'(WAIT_STATES);
    localparam bit         WS_NZ = (WAIT_STATES != 0);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic        rw_q, rw_d;
    logic        size_q, size_d;
    logic [31:0] wdat_q, wdat_d;

    logic [7:0]  mem [256];

    logic        busy;
    logic        req;
    logic [7:0]  act_addr;
    logic        act_rw;
    logic        act_size;
    logic [31:0] act_wdat;
    logic [7:0]  a0, a1, a2, a3;
    logic        mis_hit;
    logic        wr_en;
    logic [31:0] rd_word;

    assign busy = (state_q == BUSY);
    // Reset forces every output to 0 immediately, independent of the request inputs.
    assign req  = R & MEM_Enable_signal;

    // While counting wait states the latched request is authoritative; fresh inputs are ignored.
    assign act_addr = busy ? addr_q : address;
    assign act_rw   = busy ? rw_q   : MEM_RW_enable;
    assign act_size = busy ? size_q : MEM_Size_enable;
    assign act_wdat = busy ? wdat_q : data_in;

    // Byte addresses wrap modulo 256 through natural 8-bit overflow.
    assign a0 = act_addr;
    assign a1 = act_addr + 8'd1;
    assign a2 = act_addr + 8'd2;
    assign a3 = act_addr + 8'd3;

    assign mem_stall = req & ((~busy & WS_NZ) | (busy & (cnt_q != 4'd0)));
    assign mem_done  = req & ~mem_stall;

`ifdef DATA_MEM_ALIGN_CHECK_EN
    assign mis_hit = req & act_size & (act_addr[1:0] != 2'b00);
`else
    assign mis_hit = 1'b0;
`endif
    assign misalign = mis_hit;

    // Completion and commit coincide: the store lands at the edge that ends the mem_done cycle.
    assign wr_en = mem_done & act_rw & ~mis_hit;

    assign rd_word = {mem[a0], mem[a1], mem[a2], mem[a3]};

    always_comb begin
        data_out = 32'h0;
        if (req && !act_rw && !mis_hit) begin
            data_out = act_size ? rd_word : {24'h0, mem[a0]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        size_d  = size_q;
        wdat_d  = wdat_q;
        case (state_q)
            IDLE: begin
                // With zero wait states the access completes in IDLE and the FSM never leaves it.
                if (MEM_Enable_signal && WS_NZ) begin
                    addr_d  = address;
                    rw_d    = MEM_RW_enable;
                    size_d  = MEM_Size_enable;
                    wdat_d  = data_in;
                    cnt_d   = WS - 4'd1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!MEM_Enable_signal) begin
                    // Flush: abandon the access; wr_en is already low because req is low.
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 8'h0;
            rw_q    <= 1'b0;
            size_q  <= 1'b0;
            wdat_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            wdat_q  <= wdat_d;
        end
    end

    // RAM contents survive reset; the write is suppressed during reset via req.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (act_size) begin
                mem[a0] <= act_wdat[31:24];
                mem[a1] <= act_wdat[23:16];
                mem[a2] <= act_wdat[15:8];
                mem[a3] <= act_wdat[7:0];
            end else begin
                mem[a0] <= act_wdat[7:0];
            end
        end
    end

endmodule
